// File: rtl/tsbus_pkg.sv
// tsbus shared definitions: FSM states,
// width helper and parameter checks.
`ifndef TSBUS_PKG_SV
`define TSBUS_PKG_SV

`define TSBUS_CHECK(cond, lbl) \
  if (!(cond)) begin : lbl \
    $error("tsbus_arbiter: illegal parameter"); \
  end

package tsbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/tsbus_if.sv
// Request/enable bundle between requesters,
// the tristate buffer array and the arbiter.
interface tsbus_if #(
  parameter int NREQ = 4
);
  localparam int OW = tsbus_pkg::idx_w(NREQ);

  logic [NREQ-1:0] REQ;
  logic [NREQ-1:0] ENB;
  logic [NREQ-1:0] GNT;
  logic [OW-1:0]   OWNER;
  logic            BUSY;

  modport master (
    input  REQ,
    output ENB,
    output GNT,
    output OWNER,
    output BUSY
  );

  modport slave (
    output REQ,
    input  ENB,
    input  GNT,
    input  OWNER,
    input  BUSY
  );
endinterface

// File: rtl/tsbus_rr_pick.sv
// Combinational round-robin picker: first
// set request at or after ptr, wrapping.
module tsbus_rr_pick
  import tsbus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    ptr,
  output logic            valid,
  output logic [NREQ-1:0] onehot,
  output logic [W-1:0]    idx
);

  // scan from farthest to nearest so the
  // nearest candidate to ptr wins
  always_comb begin
    int k;
    k      = 0;
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NREQ;
      if (req[k]) begin
        valid = 1'b1;
        idx   = W'(k);
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/tsbus_arbiter.sv
// Round-robin owner of the tristate bus
// enables with break-before-make turnaround.
module tsbus_arbiter
  import tsbus_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input logic   CLK,
  input logic   RST,
  tsbus_if.master bus
);

  `TSBUS_CHECK(NREQ >= 2 && NREQ <= 16, g_bad_nreq)
  `TSBUS_CHECK(MAX_BURST >= 1, g_bad_burst)
  `TSBUS_CHECK(TURNAROUND >= 1, g_bad_turn)

  localparam int W  = idx_w(NREQ);
  localparam int CW = idx_w(MAX_BURST);
  localparam int TW = idx_w(TURNAROUND);

  localparam logic [CW-1:0] CNT_LAST =
    CW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TCNT_LAST =
    TW'(TURNAROUND - 1);
  localparam logic [W-1:0] PTR_LAST =
    W'(NREQ - 1);

  state_t          state, state_n;
  logic [NREQ-1:0] enb, enb_n;
  logic [W-1:0]    owner, owner_n;
  logic [W-1:0]    ptr, ptr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [TW-1:0]   tcnt, tcnt_n;

  logic            pick_valid;
  logic [NREQ-1:0] pick_onehot;
  logic [W-1:0]    pick_idx;

  tsbus_rr_pick #(
    .NREQ (NREQ),
    .W    (W)
  ) u_pick (
    .req    (bus.REQ),
    .ptr    (ptr),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // next-state, burst and turnaround control
  always_comb begin
    state_n = state;
    enb_n   = enb;
    owner_n = owner;
    ptr_n   = ptr;
    cnt_n   = cnt;
    tcnt_n  = tcnt;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          enb_n   = pick_onehot;
          owner_n = pick_idx;
          cnt_n   = '0;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (bus.REQ[owner] &&
            cnt != CNT_LAST) begin
          cnt_n = cnt + 1'b1;
        end else begin
          enb_n   = '0;
          ptr_n   = (owner == PTR_LAST) ?
                    '0 : owner + 1'b1;
          tcnt_n  = '0;
          state_n = TURN;
        end
      end
      TURN: begin
        if (tcnt != TCNT_LAST) begin
          tcnt_n = tcnt + 1'b1;
        end else if (pick_valid) begin
          enb_n   = pick_onehot;
          owner_n = pick_idx;
          cnt_n   = '0;
          state_n = DRIVE;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        enb_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // state and registered enables
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      enb   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      enb   <= enb_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      tcnt  <= tcnt_n;
    end
  end

  assign bus.ENB   = enb;
  assign bus.GNT   = enb;
  assign bus.OWNER = owner;
  assign bus.BUSY  = |enb;

endmodule

// File: tb/tb_tsbus_arbiter.sv
// Scoreboard bench for tsbus_arbiter with
// TURNAROUND=1 and TURNAROUND=3 instances.
module tb_tsbus_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [N-1:0] req = '0;

  always #5 CLK = ~CLK;

  tsbus_if #(.NREQ(N)) bus_a ();
  tsbus_if #(.NREQ(N)) bus_b ();

  assign bus_a.REQ = req;
  assign bus_b.REQ = req;

  tsbus_arbiter #(
    .NREQ       (N),
    .MAX_BURST  (MB),
    .TURNAROUND (1)
  ) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a.master)
  );

  tsbus_arbiter #(
    .NREQ       (N),
    .MAX_BURST  (MB),
    .TURNAROUND (3)
  ) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b.master)
  );

  typedef struct {
    int own;
    int held;
    int gap;
    int pref;
    int last;
  } mdl_t;

  typedef struct packed {
    logic [N-1:0] enb;
    logic [1:0]   own;
    logic         busy;
  } exp_t;

  mdl_t m_a, m_b;
  exp_t q_a[$];
  exp_t q_b[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic mdl_t step(
    input mdl_t s, input logic [N-1:0] r,
    input logic rs, input int ta);
    mdl_t o;
    int k;
    o = s;
    if (rs) begin
      o.own = -1; o.held = 0; o.gap = 0;
      o.pref = 0; o.last = 0;
      return o;
    end
    if (o.own >= 0) begin
      if (r[o.own] && o.held < MB) begin
        o.held++;
      end else begin
        o.pref = (o.own + 1) % N;
        o.own  = -1;
        o.gap  = ta;
      end
    end else if (o.gap > 1) begin
      o.gap--;
    end else begin
      o.gap = 0;
      for (int i = 0; i < N; i++) begin
        k = (o.pref + i) % N;
        if (o.own < 0 && r[k]) begin
          o.own  = k;
          o.held = 1;
          o.last = k;
        end
      end
    end
    return o;
  endfunction

  function automatic exp_t expect_of(
    input mdl_t s);
    exp_t e;
    e.enb  = (s.own >= 0) ?
             N'(1 << s.own) : '0;
    e.own  = 2'(s.last);
    e.busy = (s.own >= 0);
    return e;
  endfunction

  function automatic void check(
    input string nm,
    input logic [N-1:0] enb,
    input logic [N-1:0] gnt,
    input logic [1:0] own,
    input logic busy,
    input exp_t e);
    compared++;
    if (enb !== e.enb || gnt !== e.enb ||
        own !== e.own || busy !== e.busy) begin
      mismatched++;
      $display("FAIL %s t=%0t enb=%b gnt=%b owner=%0d busy=%b required enb=%b owner=%0d busy=%b",
               nm, $time, enb, gnt, own, busy,
               e.enb, e.own, e.busy);
    end
  endfunction

  task automatic cyc(
    input logic [N-1:0] r, input logic rs);
    @(negedge CLK);
    req = r;
    RST = rs;
    m_a = step(m_a, r, rs, 1);
    m_b = step(m_b, r, rs, 3);
    q_a.push_back(expect_of(m_a));
    q_b.push_back(expect_of(m_b));
  endtask

  task automatic hold(
    input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) cyc(r, 1'b0);
  endtask

  // monitor: compare each DUT against its queue
  always begin
    @(posedge CLK);
    #1;
    if (q_a.size() > 0)
      check("arb_ta1", bus_a.ENB, bus_a.GNT,
            bus_a.OWNER, bus_a.BUSY,
            q_a.pop_front());
    if (q_b.size() > 0)
      check("arb_ta3", bus_b.ENB, bus_b.GNT,
            bus_b.OWNER, bus_b.BUSY,
            q_b.pop_front());
  end

  initial begin
    logic [N-1:0] r;
    logic rs;
    m_a = '{-1, 0, 0, 0, 0};
    m_b = '{-1, 0, 0, 0, 0};

    cyc(4'b1111, 1'b1);
    cyc(4'b1111, 1'b1);
    hold(4'b1111, 3);
    hold(4'b0000, 6);

    hold(4'b0100, 3);
    hold(4'b0000, 6);

    hold(4'b0010, 20);
    hold(4'b0000, 6);

    hold(4'b1111, 45);
    hold(4'b0000, 6);

    hold(4'b0010, 3);
    hold(4'b1010, 2);
    hold(4'b1000, 8);
    hold(4'b0000, 6);

    hold(4'b0100, 3);
    cyc(4'b0100, 1'b1);
    hold(4'b0101, 4);
    hold(4'b0000, 6);

    r = '0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0)
        r = N'($urandom);
      rs = ($urandom_range(0, 79) == 0);
      cyc(r, rs);
    end
    hold(4'b0000, 6);

    repeat (3) @(posedge CLK);
    #2;
    compared++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d/%0d required 0/0",
               q_a.size(), q_b.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tsbus_arbiter.md
# tsbus_arbiter

Round-robin arbiter that shares one tristate bus segment among `NREQ` drivers built from `TNBUFFX2` cells. It turns requester `REQ` lines into one-hot, registered `ENB` enables for the buffer array. Between owners it always inserts a break-before-make turnaround, so two drivers never contend on `Z`. It sits beside the buffer array in the shared-bus macro and owns every buffer `ENB` pin.

## Interface
Parameters:
- `NREQ`, 4: number of requesters / tristate drivers; legal range 2..16.
- `MAX_BURST`, 8: maximum consecutive cycles one owner may hold the bus; must be ≥ 1.
- `TURNAROUND`, 1: all-off cycles between owners; must be ≥ 1 (0 is an elaboration error).

Ports:
- `CLK` in 1: the single clock; all state changes on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `REQ` in `NREQ`: per-requester bus request, level-sensitive.
- `ENB` out `NREQ`: registered one-hot drive enables, one per `TNBUFFX2` `ENB` pin.
- `GNT` out `NREQ`: registered grant, identical to `ENB`, for requester-side logic.
- `OWNER` out `$clog2(NREQ)`: index of the current owner; valid only while `BUSY` is high.
- `BUSY` out 1: high when any `ENB` bit is high.

## Operation
- States:
  - `IDLE`: no enables.
  - `DRIVE`: one owner enabled.
  - `TURN`: all enables low for `TURNAROUND` cycles.
- `IDLE`:
  - If any `REQ` bit is set, pick a winner round-robin starting at `ptr`. Load `ENB`/`GNT` one-hot for the winner, set `cnt`=0, and go to `DRIVE`.
  - Otherwise stay in `IDLE`.
- `DRIVE`:
  - If `REQ[OWNER]`=1 and `cnt` ≠ `MAX_BURST-1`: stay, `cnt`++.
  - Otherwise: clear `ENB`/`GNT`, set `ptr` = `OWNER+1` mod `NREQ`, load `tcnt`=0, go to `TURN`.
- `TURN`:
  - While `tcnt` < `TURNAROUND-1`: `tcnt`++.
  - On the last turnaround cycle, arbitrate exactly as in `IDLE` and go directly to `DRIVE`, or to `IDLE` if no requests.
- Round-robin: lowest index at or after `ptr` with `REQ` set, wrapping at `NREQ-1` → 0.
  - A released owner that re-requests is served after every other pending requester.
  - If it is the only requester, it is re-granted after the turnaround.
- Requests from non-owners during `DRIVE` do not preempt. They only wait for release or burst expiry.
- Invariants:
  - popcount(`ENB`) ≤ 1 every cycle.
  - `ENB` never moves from one bit to a different bit without at least `TURNAROUND` intervening all-zero cycles.
  - `GNT` == `ENB` always.
- `OWNER` holds its last value when not `BUSY`; it is 0 after reset.

## Timing
- Reset: on an edge with `RST`=1, `ENB`=0, `GNT`=0, `BUSY`=0, `OWNER`=0, `ptr`=0, `cnt`=0, `tcnt`=0, state `IDLE`.
  - `RST` asserted mid-`DRIVE` or mid-`TURN` aborts immediately with the same values.
- Grant latency from `IDLE`: `REQ` sampled high at edge t → `ENB` high after edge t (one cycle).
- Release tail: owner's `REQ` sampled low at edge t → `ENB` low after edge t. The cycle before edge t is the owner's last driven cycle.
- Handover: release seen at edge t → next owner's `ENB` high after edge t+`TURNAROUND`.
- Burst limit: with `REQ` held continuously, `ENB` stays high exactly `MAX_BURST` cycles, then `TURN` is entered regardless of `REQ`.
- `MAX_BURST`=1: every grant lasts one cycle, followed by turnaround.
- Simultaneous owner release and new requests on the same edge: release wins; new requests are arbitrated at the end of `TURN`.

## Structure
- Shared package `tsbus_pkg`:
  - state enum (`IDLE`, `DRIVE`, `TURN`).
  - constant function for `OWNER` width (`$clog2` with a minimum of 1).
  - parameter-legality check macros.
- One sub-module, `tsbus_rr_pick`: combinational round-robin picker. Inputs are `REQ` and `ptr`; outputs are `valid`, a one-hot vector and an index.
- Top level holds the FSM, `cnt`, `tcnt`, `ptr` and the output registers.

## Test plan
- Reset behaviour: `RST`=1 for 2 cycles with `REQ`=4'b1111 → `ENB`=0, `BUSY`=0, `OWNER`=0. After release, `ENB`=4'b0001 one cycle later.
- Single requester: `REQ`=4'b0100 for 3 cycles then 0 (`MAX_BURST`=8) → `ENB`=4'b0100 for exactly 3 cycles starting one cycle after `REQ` rise, then 0.
- Burst cap: `REQ`=4'b0010 held 20 cycles (`MAX_BURST`=8, `TURNAROUND`=1) → `ENB`=4'b0010 for 8 cycles, 1 zero cycle, then 8 more.
- Fairness: `REQ`=4'b1111 held continuously → grant order 0,1,2,3,0 with one all-zero cycle between each. popcount(`ENB`) ≤ 1 every cycle.
- Turnaround width: `TURNAROUND`=3, owner 1 releases while `REQ[3]` is high → `ENB` all zero for 3 cycles, then 4'b1000.
- Mid-operation reset: `RST` pulsed during `DRIVE` of owner 2 → `ENB`=0 next cycle. Next grant follows `ptr`=0 order, so `REQ`=4'b0101 grants 0.
